// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states, opcode/funct
// codes, ALU operation codes and datapath mux selections.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_TARGET = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // Terminal states hand the instruction back to FETCH and retire it.
  function automatic logic retires(input state_t s, input logic mem_ready);
    return (s == S_WB_R) || (s == S_WB_I) || (s == S_WB_LW) || (s == S_BRANCH) ||
           (s == S_JUMP) || ((s == S_MEM_WR) && mem_ready);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR fields and status flags in, datapath
// enables and mux selects out.
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             ir_zero;
  logic             alu_zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             illegal;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, ir_zero, alu_zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal, halted, instr_count
  );

  modport slave (
    output opcode, funct, ir_zero, alu_zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal, halted, instr_count
  );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct to ALU operation; valid is low for any funct the ALU path does not support.
module multicycle_control_alu_op_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the shared multi-cycle MIPS datapath. Outputs decode from the
// current state, qualified only by mem_ready (FETCH) and alu_zero (BRANCH).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  multicycle_control_if.master bus
);

  state_t           state;
  state_t           out_state;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       r_alu_op;
  logic             r_valid;
  logic             is_jr, is_r_alu, is_jump, is_imm, is_mem, is_branch;

  multicycle_control_alu_op_decode u_alu_op_decode (
    .funct  (bus.funct),
    .alu_op (r_alu_op),
    .valid  (r_valid)
  );

  // The IR is held after FETCH, so opcode/funct stay valid through every later state.
  assign is_jr     = (bus.opcode == OP_SPECIAL) && (bus.funct == FN_JR);
  assign is_r_alu  = (bus.opcode == OP_SPECIAL) && r_valid;
  assign is_jump   = is_jr || (bus.opcode == OP_J) || (bus.opcode == OP_JAL);
  assign is_imm    = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ORI);
  assign is_mem    = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
  assign is_branch = (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      if (retires(state, bus.mem_ready)) instr_count <= instr_count + CNT_W'(1);
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (bus.ir_zero)     state <= S_HALT;
          else if (is_r_alu)   state <= S_EXEC_R;
          else if (is_jump)    state <= S_JUMP;
          else if (is_imm)     state <= S_EXEC_I;
          else if (is_mem)     state <= S_MEM_ADDR;
          else if (is_branch)  state <= S_BRANCH;
          else                 state <= S_FETCH;
        end
        S_EXEC_R:   state <= S_WB_R;
        S_EXEC_I:   state <= S_WB_I;
        S_MEM_ADDR: state <= (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (bus.mem_ready) state <= S_WB_LW;
        S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs already look like FETCH, so nothing but the fetch read is asserted.
  assign out_state       = reset_n ? state : S_FETCH;
  assign bus.instr_count = instr_count;

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = PCS_ALU;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = DST_RT;
    bus.mem_to_reg    = WB_ALUOUT;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_RT;
    bus.alu_op        = ALU_AND;
    bus.illegal       = 1'b0;
    bus.halted        = 1'b0;
    case (out_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALU_ADD;
        bus.ir_write  = bus.mem_ready && reset_n;
        bus.pc_write  = bus.mem_ready && reset_n;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_BOFS;
        bus.alu_op    = ALU_ADD;
        bus.illegal   = !bus.ir_zero &&
                        !(is_r_alu || is_jump || is_imm || is_mem || is_branch);
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = r_alu_op;
      end
      S_WB_R: begin
        bus.reg_dst   = DST_RD;
        bus.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = (bus.opcode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_WB_I:     bus.reg_write = 1'b1;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_WB_LW: begin
        bus.mem_to_reg = WB_MDR;
        bus.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_source     = PCS_TARGET;
        bus.pc_write_cond = (bus.opcode == OP_BEQ) ? bus.alu_zero : !bus.alu_zero;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = is_jr ? PCS_RS : PCS_JUMP;
        if (bus.opcode == OP_JAL) begin
          bus.reg_dst    = DST_RA;
          bus.mem_to_reg = WB_PC;
          bus.reg_write  = 1'b1;
        end
      end
      S_HALT:  bus.halted = 1'b1;
      default: bus.halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction phase model; a scoreboard
// queue carries the expected control word for every cycle to an independent monitor.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       illegal;
    logic       halted;
  } ctl_t;

  typedef struct {
    ctl_t             exp;
    ctl_t             care;
    logic [CNT_W-1:0] cnt;
    string            tag;
  } item_t;

  typedef enum {P_FETCH, P_DECODE, P_EXR, P_WBR, P_EXI, P_WBI, P_ADDR, P_MRD, P_WBLW,
                P_MWR, P_BR, P_JMP, P_HALT} phase_t;
  typedef enum {K_R, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR,
                K_ILL, K_HALT} kind_t;

  localparam logic [5:0] R_FN   [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  localparam logic [2:0] R_AO   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  localparam logic [5:0] ILL_OP [4] = '{6'h3F, 6'h01, 6'h10, 6'h00};
  localparam logic [5:0] ILL_FN [4] = '{6'h00, 6'h00, 6'h00, 6'h21};

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  multicycle_control_if #(.CNT_W(CNT_W)) bus();
  multicycle_control #(.CNT_W(CNT_W)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  item_t            sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] mcount = '0;
  logic [5:0]       cur_op = '0;
  logic [5:0]       cur_fn = '0;
  logic             cur_irz = 1'b0;
  logic             cur_ill = 1'b0;
  logic [2:0]       cur_ao = '0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control word for one cycle of the given phase of the current instruction.
  task automatic phase(input phase_t p, input logic rdy, input logic az, input logic rst_n);
    ctl_t e, c;
    e = '0;
    c = '0;
    c.pc_write = 1'b1; c.pc_write_cond = 1'b1; c.mem_read = 1'b1; c.mem_write = 1'b1;
    c.ir_write = 1'b1; c.reg_write = 1'b1; c.illegal = 1'b1; c.halted = 1'b1;
    case (p)
      P_FETCH: begin
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b010;
        e.ir_write = rdy && rst_n; e.pc_write = rdy && rst_n;
        c.iord = 1'b1; c.pc_source = '1; c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      P_DECODE: begin
        e.alu_src_b = 2'b11; e.alu_op = 3'b010; e.illegal = cur_ill;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      P_EXR: begin
        e.alu_src_a = 1'b1; e.alu_op = cur_ao;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      P_WBR: begin
        e.reg_dst = 2'b01; e.reg_write = 1'b1;
        c.reg_dst = '1; c.mem_to_reg = '1;
      end
      P_EXI: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        e.alu_op = (cur_op == 6'h0D) ? 3'b001 : 3'b010;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      P_WBI: begin
        e.reg_write = 1'b1;
        c.reg_dst = '1;
      end
      P_ADDR: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b010;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      end
      P_MRD: begin
        e.iord = 1'b1; e.mem_read = 1'b1;
        c.iord = 1'b1;
      end
      P_WBLW: begin
        e.mem_to_reg = 2'b01; e.reg_write = 1'b1;
        c.reg_dst = '1; c.mem_to_reg = '1;
      end
      P_MWR: begin
        e.iord = 1'b1; e.mem_write = 1'b1;
        c.iord = 1'b1;
      end
      P_BR: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'b110; e.pc_source = 2'b01;
        e.pc_write_cond = (cur_op == 6'h04) ? az : !az;
        c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1; c.pc_source = '1;
      end
      P_JMP: begin
        e.pc_write = 1'b1;
        e.pc_source = (cur_op == 6'h00) ? 2'b11 : 2'b10;
        c.pc_source = '1;
        if (cur_op == 6'h03) begin
          e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.reg_write = 1'b1;
          c.reg_dst = '1; c.mem_to_reg = '1;
        end
      end
      P_HALT: e.halted = 1'b1;
      default: e.halted = 1'b0;
    endcase
    reset_n       = rst_n;
    bus.mem_ready = rdy;
    bus.alu_zero  = az;
    bus.opcode    = cur_op;
    bus.funct     = cur_fn;
    bus.ir_zero   = cur_irz;
    sb.push_back('{exp: e, care: c, cnt: mcount, tag: p.name()});
    @(posedge clock);
    #1;
  endtask

  task automatic fetch_decode(input int wf);
    for (int i = 0; i < wf; i++) phase(P_FETCH, 1'b0, rb(), 1'b1);
    phase(P_FETCH, 1'b1, rb(), 1'b1);
    phase(P_DECODE, rb(), rb(), 1'b1);
  endtask

  task automatic run(input kind_t k, input int sel, input int wf, input int wm, input logic az);
    cur_irz = 1'b0;
    cur_ill = 1'b0;
    cur_fn  = 6'($urandom_range(0, 63));
    case (k)
      K_R:    begin cur_op = 6'h00; cur_fn = R_FN[sel]; cur_ao = R_AO[sel]; end
      K_ADDI: cur_op = 6'h08;
      K_ORI:  cur_op = 6'h0D;
      K_LW:   cur_op = 6'h23;
      K_SW:   cur_op = 6'h2B;
      K_BEQ:  cur_op = 6'h04;
      K_BNE:  cur_op = 6'h05;
      K_J:    cur_op = 6'h02;
      K_JAL:  cur_op = 6'h03;
      K_JR:   begin cur_op = 6'h00; cur_fn = 6'h08; end
      K_ILL:  begin cur_op = ILL_OP[sel]; cur_fn = ILL_FN[sel]; cur_ill = 1'b1; end
      default: begin cur_op = 6'h00; cur_fn = 6'h00; cur_irz = 1'b1; end
    endcase
    fetch_decode(wf);
    case (k)
      K_R:          begin phase(P_EXR, rb(), rb(), 1'b1); phase(P_WBR, rb(), rb(), 1'b1); end
      K_ADDI, K_ORI: begin phase(P_EXI, rb(), rb(), 1'b1); phase(P_WBI, rb(), rb(), 1'b1); end
      K_LW: begin
        phase(P_ADDR, rb(), rb(), 1'b1);
        for (int i = 0; i < wm; i++) phase(P_MRD, 1'b0, rb(), 1'b1);
        phase(P_MRD, 1'b1, rb(), 1'b1);
        phase(P_WBLW, rb(), rb(), 1'b1);
      end
      K_SW: begin
        phase(P_ADDR, rb(), rb(), 1'b1);
        for (int i = 0; i < wm; i++) phase(P_MWR, 1'b0, rb(), 1'b1);
        phase(P_MWR, 1'b1, rb(), 1'b1);
      end
      K_BEQ, K_BNE:      phase(P_BR, rb(), az, 1'b1);
      K_J, K_JAL, K_JR:  phase(P_JMP, rb(), rb(), 1'b1);
      K_HALT: for (int i = 0; i < 50; i++) phase(P_HALT, rb(), rb(), 1'b1);
      default: ;
    endcase
    if (k != K_ILL && k != K_HALT) mcount = mcount + 1'b1;
  endtask

  task automatic hard_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    mcount = '0;
  endtask

  item_t mon_it;
  ctl_t  mon_act;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_it  = sb.pop_front();
      mon_act = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                 bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal, bus.halted};
      checks++;
      if ((mon_act & mon_it.care) !== (mon_it.exp & mon_it.care)) begin
        errors++;
        $display("FAIL ctl_%s t=%0t: actual %b required %b (care %b)", mon_it.tag, $time,
                 mon_act, mon_it.exp, mon_it.care);
      end
      checks++;
      if (bus.instr_count !== mon_it.cnt) begin
        errors++;
        $display("FAIL instr_count_%s t=%0t: actual %0d required %0d", mon_it.tag, $time,
                 bus.instr_count, mon_it.cnt);
      end
      checks++;
      if ((bus.mem_read && bus.mem_write) || (bus.reg_write && bus.mem_write)) begin
        errors++;
        $display("FAIL exclusive_%s t=%0t: actual rd=%b wr=%b rw=%b required no overlap",
                 mon_it.tag, $time, bus.mem_read, bus.mem_write, bus.reg_write);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required stimulus completion");
    $fatal(1, "watchdog");
  end

  initial begin
    kind_t k;
    bus.opcode = '0; bus.funct = '0; bus.ir_zero = 1'b0; bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0;
    hard_reset();
    phase(P_FETCH, 1'b0, 1'b0, 1'b1);
    run(K_R, 0, 0, 0, 1'b0);
    run(K_LW, 0, 0, 2, 1'b0);
    run(K_BEQ, 0, 0, 0, 1'b1);
    run(K_BNE, 0, 0, 0, 1'b1);
    run(K_JAL, 0, 0, 0, 1'b0);
    run(K_JR, 0, 0, 0, 1'b0);
    run(K_ILL, 0, 0, 0, 1'b0);
    for (int n = 0; n < 250; n++) begin
      k = kind_t'($urandom_range(0, 10));
      run(k, (k == K_R) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rb());
    end
    run(K_HALT, 0, 1, 0, 1'b0);
    hard_reset();
    run(K_ORI, 0, 0, 0, 1'b0);
    cur_op = 6'h2B; cur_ill = 1'b0; cur_irz = 1'b0;
    fetch_decode(0);
    phase(P_ADDR, 1'b1, 1'b0, 1'b1);
    phase(P_MWR, 1'b0, 1'b0, 1'b1);
    phase(P_FETCH, 1'b1, 1'b0, 1'b0);
    mcount = '0;
    phase(P_FETCH, 1'b0, 1'b0, 1'b1);
    run(K_ADDI, 0, 0, 0, 1'b0);
    @(posedge clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
